// File: rtl/lz77_pkg.sv
// Shared LZ77 constants, state encoding and count helper used by the buffer
// and match-engine controllers.
package lz77_pkg;

    localparam int unsigned DEPTH = 30;
    localparam int unsigned CW    = 5;
    localparam int unsigned DW    = 8;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   cntx_t;
    typedef logic [DW-1:0] byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        READY = 3'd2,
        ADV   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Strobes actually issuable: requested length clipped to the bytes left behind pos.
    function automatic cntx_t adv_count(input cnt_t len, input cnt_t pos, input cnt_t blen);
        cntx_t avail;
        avail = (cntx_t'(blen) > cntx_t'(pos)) ?
                (cntx_t'(blen) - cntx_t'(pos) - cntx_t'(1)) : '0;
        return (cntx_t'(len) < avail) ? cntx_t'(len) : avail;
    endfunction

endpackage

// File: rtl/lz77_buffer_ctrl_if.sv
// Byte-source, buffer-strobe and match-engine signals of the buffer controller.
interface lz77_buffer_ctrl_if;
    import lz77_pkg::*;

    logic  start;
    logic  in_valid;
    byte_t in_data;
    logic  in_last;
    logic  in_ready;
    byte_t buf_data_in;
    logic  buf_load_input;
    logic  buf_load;
    logic  adv_req;
    cnt_t  adv_len;
    logic  adv_ack;
    cnt_t  pos;
    cnt_t  block_len;
    logic  busy;
    logic  done;

    modport slave (
        input  start, in_valid, in_data, in_last, adv_req, adv_len,
        output in_ready, buf_data_in, buf_load_input, buf_load,
               adv_ack, pos, block_len, busy, done
    );

    modport master (
        output start, in_valid, in_data, in_last, adv_req, adv_len,
        input  in_ready, buf_data_in, buf_load_input, buf_load,
               adv_ack, pos, block_len, busy, done
    );

endinterface

// File: rtl/lz77_buffer_ctrl.sv
// Fills the LZ77 input buffer from a byte stream, then steps its output
// forward on advance requests from the match engine until end of block.
module lz77_buffer_ctrl
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lz77_buffer_ctrl_if.slave bus
);

    state_e state_q, state_d;
    cnt_t   wr_cnt_q, wr_cnt_d;
    cnt_t   block_len_q, block_len_d;
    cnt_t   pos_q, pos_d;
    cnt_t   ld_cnt_q, ld_cnt_d;
    logic   fin_q, fin_d;
    byte_t  buf_data_in_q, buf_data_in_d;
    logic   buf_load_input_q, buf_load_input_d;
    logic   buf_load_q, buf_load_d;
    logic   adv_ack_q, adv_ack_d;
    logic   in_ready_q, in_ready_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic   accept_c;
    logic   last_byte_c;
    cntx_t  n_c;
    logic   fin_c;

    assign accept_c    = (state_q == FILL) && bus.in_valid && in_ready_q;
    assign last_byte_c = bus.in_last || (wr_cnt_q == CW'(DEPTH - 1));
    assign n_c         = adv_count(bus.adv_len, pos_q, block_len_q);
    assign fin_c       = (cntx_t'(pos_q) + cntx_t'(bus.adv_len)) >= cntx_t'(block_len_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FILL;
            FILL:    if (accept_c && last_byte_c) state_d = READY;
            READY: begin
                if (bus.adv_req) begin
                    if (n_c != '0) state_d = ADV;
                    else           state_d = fin_c ? DONE : READY;
                end
            end
            ADV:     if (ld_cnt_q == '0) state_d = fin_q ? DONE : READY;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath counters.
    always_comb begin
        wr_cnt_d         = wr_cnt_q;
        block_len_d      = block_len_q;
        pos_d            = pos_q + CW'(buf_load_q);
        ld_cnt_d         = ld_cnt_q;
        fin_d            = fin_q;
        buf_data_in_d    = buf_data_in_q;
        buf_load_input_d = 1'b0;
        buf_load_d       = 1'b0;
        adv_ack_d        = 1'b0;
        case (state_q)
            FILL: begin
                if (accept_c) begin
                    buf_load_input_d = 1'b1;
                    buf_data_in_d    = bus.in_data;
                    wr_cnt_d         = wr_cnt_q + CW'(1);
                    block_len_d      = wr_cnt_q + CW'(1);
                end
            end
            READY: begin
                if (bus.adv_req) begin
                    fin_d     = fin_c;
                    ld_cnt_d  = CW'(n_c);
                    adv_ack_d = (n_c == '0);
                end
            end
            ADV: begin
                if (ld_cnt_q != '0) begin
                    buf_load_d = 1'b1;
                    ld_cnt_d   = ld_cnt_q - CW'(1);
                end else begin
                    adv_ack_d  = 1'b1;
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d == FILL) && (wr_cnt_d < CW'(DEPTH));
        busy_d     = (state_d == FILL) || (state_d == ADV);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q         <= '0;
            block_len_q      <= '0;
            pos_q            <= '0;
            ld_cnt_q         <= '0;
            fin_q            <= 1'b0;
            buf_data_in_q    <= '0;
            buf_load_input_q <= 1'b0;
            buf_load_q       <= 1'b0;
            adv_ack_q        <= 1'b0;
            in_ready_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            wr_cnt_q         <= wr_cnt_d;
            block_len_q      <= block_len_d;
            pos_q            <= pos_d;
            ld_cnt_q         <= ld_cnt_d;
            fin_q            <= fin_d;
            buf_data_in_q    <= buf_data_in_d;
            buf_load_input_q <= buf_load_input_d;
            buf_load_q       <= buf_load_d;
            adv_ack_q        <= adv_ack_d;
            in_ready_q       <= in_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.buf_data_in    = buf_data_in_q;
    assign bus.buf_load_input = buf_load_input_q;
    assign bus.buf_load       = buf_load_q;
    assign bus.adv_ack        = adv_ack_q;
    assign bus.pos            = pos_q;
    assign bus.block_len      = block_len_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_lz77_buffer_ctrl.sv
// Scoreboard bench for lz77_buffer_ctrl: directed fills and advances with
// hand-computed write bytes, strobe counts, positions and end-of-block flags.
module tb_lz77_buffer_ctrl;
    import lz77_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lz77_buffer_ctrl_if bus();

    lz77_buffer_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int load_total  = 0;
    int load_at_ack = 0;
    int ack_count   = 0;

    byte_t exp_wr_q[$];
    int    exp_wr_cyc_q[$];
    int    exp_ack_ld_q[$];
    int    exp_ack_pos_q[$];
    int    exp_ack_done_q[$];

    byte_t mon_d;
    int    mon_c;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected writes/acks as the DUT presents strobes.
    always @(negedge clk) begin
        if (bus.buf_load_input) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                mon_d = exp_wr_q.pop_front();
                mon_c = exp_wr_cyc_q.pop_front();
                chk("wr_data", int'(bus.buf_data_in), int'(mon_d));
                chk("wr_cycle", cyc, mon_c);
            end
        end
        if (bus.buf_load || bus.buf_load_input)
            chk("strobe_overlap", int'(bus.buf_load && bus.buf_load_input), 0);
        if (bus.buf_load) load_total++;
        if (bus.adv_ack) begin
            if (exp_ack_ld_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                chk("ack_strobes", load_total - load_at_ack, exp_ack_ld_q.pop_front());
                chk("ack_pos", int'(bus.pos), exp_ack_pos_q.pop_front());
                chk("ack_done", int'(bus.done), exp_ack_done_q.pop_front());
            end
            ack_count++;
        end
        if (bus.adv_ack || rst) load_at_ack = load_total;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_buf_load_input", int'(bus.buf_load_input), 0);
        chk("rst_buf_load", int'(bus.buf_load), 0);
        chk("rst_adv_ack", int'(bus.adv_ack), 0);
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_block_len", int'(bus.block_len), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.adv_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs();
    endtask

    // Stream n bytes base, base+1, ...; only the first DEPTH may be accepted.
    task automatic fill(input byte_t base, input int n, input int last_idx);
        bit exp_acc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("fill_busy", int'(bus.busy), 1);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = byte_t'(int'(base) + i);
            bus.in_last  = (i == last_idx);
            exp_acc = (i < int'(DEPTH));
            chk("in_ready", int'(bus.in_ready), int'(exp_acc));
            if (exp_acc) begin
                exp_wr_q.push_back(byte_t'(int'(base) + i));
                exp_wr_cyc_q.push_back(cyc + 1);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic advance(input int len, input int exp_ld, input int exp_pos, input int exp_done);
        int prev;
        int n;
        prev = ack_count;
        exp_ack_ld_q.push_back(exp_ld);
        exp_ack_pos_q.push_back(exp_pos);
        exp_ack_done_q.push_back(exp_done);
        bus.adv_req = 1'b1;
        bus.adv_len = cnt_t'(len);
        tick();
        bus.adv_req = 1'b0;
        n = 0;
        while (ack_count == prev && n < 64) begin
            tick();
            n++;
        end
        if (ack_count == prev) chk("ack_timeout", 0, 1);
        chk("ack_pulse_width", int'(bus.adv_ack), 0);
    endtask

    initial begin
        int base_ld;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.adv_req  = 1'b0;
        bus.adv_len  = '0;

        // Five-byte block, advance 3 then overshoot to end of block.
        do_reset();
        fill(8'h41, 5, 4);
        chk("t1_block_len", int'(bus.block_len), 5);
        chk("t1_pos", int'(bus.pos), 0);
        chk("t1_ready_busy", int'(bus.busy), 0);
        chk("t1_ready_in_ready", int'(bus.in_ready), 0);
        advance(3, 3, 3, 0);
        chk("t3_done", int'(bus.done), 0);
        advance(4, 1, 4, 1);
        repeat (3) tick();
        chk("t4_done_held", int'(bus.done), 1);
        chk("t4_pos_held", int'(bus.pos), 4);

        // Overlong stream: only DEPTH bytes taken.
        do_reset();
        fill(8'h80, 34, -1);
        chk("t2_block_len", int'(bus.block_len), 30);
        advance(29, 29, 29, 0);
        advance(1, 0, 29, 1);

        // Zero-length advance away from the start.
        do_reset();
        fill(8'h30, 5, 4);
        advance(1, 1, 1, 0);
        advance(0, 0, 1, 0);
        chk("t5_pos", int'(bus.pos), 1);
        chk("t5_done", int'(bus.done), 0);

        // Single-byte block ends on any advance; start ignored in DONE.
        do_reset();
        fill(8'h55, 1, 0);
        chk("t7_block_len", int'(bus.block_len), 1);
        advance(3, 0, 0, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t7_done_after_start", int'(bus.done), 1);
        chk("t7_in_ready_after_start", int'(bus.in_ready), 0);

        // Reset in the middle of an advance, then refill.
        do_reset();
        fill(8'h60, 10, 9);
        tick();
        base_ld = load_total;
        bus.adv_req = 1'b1;
        bus.adv_len = cnt_t'(6);
        tick();
        bus.adv_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs();
        chk("t6_strobes_before_rst", load_total - base_ld, 2);
        repeat (5) tick();
        chk("t6_no_strobes_after_rst", load_total - base_ld, 2);
        fill(8'h70, 5, 4);
        chk("t6_refill_block_len", int'(bus.block_len), 5);
        chk("t6_refill_pos", int'(bus.pos), 0);
        advance(4, 4, 4, 0);

        repeat (3) tick();
        chk("writes_drained", exp_wr_q.size(), 0);
        chk("acks_drained", exp_ack_ld_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz77_buffer_ctrl.md
Name: lz77_buffer_ctrl

Overview:
Sequencing controller for the LZ77 30-byte input buffer.
- Accepts an upstream byte stream on a valid/ready handshake and writes it into the buffer with one write strobe per byte.
- Then serves "advance by L" requests from the match engine by issuing L read strobes, moving the buffer's output byte forward through the block.
- Tracks the block length and the current read position, and flags end of block.
- Sits between the byte source and the buffer; the match engine talks only to this block.

Parameters:
DEPTH, 30, buffer capacity in bytes.
CW, 5, width of counts and positions; must satisfy 2^CW > DEPTH.
DW, 8, byte width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset. The same net also resets the buffer.
start  in  1  begin filling a new block; honoured only in IDLE.
in_valid  in  1  upstream byte valid.
in_data  in  DW  upstream byte.
in_last  in  1  marks the final byte of the block; qualified by in_valid.
in_ready  out  1  controller accepts in_data this cycle.
buf_data_in  out  DW  byte to buffer (registered).
buf_load_input  out  1  buffer write strobe (registered).
buf_load  out  1  buffer read/advance strobe (registered).
adv_req  in  1  match engine requests an advance; sampled only in READY.
adv_len  in  CW  number of positions to advance, 0..DEPTH.
adv_ack  out  1  one-cycle pulse: advance complete.
pos  out  CW  index of the byte currently on the buffer output.
block_len  out  CW  number of bytes written in this block.
busy  out  1  high in FILL or ADV.
done  out  1  end of block reached; held until rst.

Behaviour:
Reset (rst=1 at a clock edge):
- state=IDLE.
- All strobes, in_ready, adv_ack and done are 0.
- pos, block_len and the write/read counters are 0.
- Reset mid-FILL or mid-ADV aborts at once. No strobe is issued in the cycle after reset.

States: IDLE, FILL, READY, ADV, DONE.

IDLE:
- in_ready=0.
- start=1 -> FILL.

FILL:
- in_ready=1 while wr_cnt<DEPTH.
- Accept on in_valid&in_ready. The next cycle drives buf_load_input=1 with buf_data_in equal to the accepted byte. Write latency is 1 cycle and sustains 1 byte per cycle.
- wr_cnt increments on each accept.
- Leave FILL after accepting in_last=1, or after accepting the DEPTH-th byte (in_last is ignored there): next state is READY and block_len=wr_cnt. The final write strobe coincides with the first READY cycle.
- in_valid=0 stalls without issuing a strobe.
- Byte 0 reaches the buffer output on its own write, so pos=0 on entry to READY.

READY:
- Wait for adv_req. Latch L=adv_len.
- Compute n = min(L, block_len-1-pos) using CW+1-bit arithmetic; n never underflows.
- n>0 -> ADV.
- n=0 -> pulse adv_ack next cycle; if pos+L >= block_len, then DONE, else stay in READY.

ADV:
- Issue buf_load=1 on n consecutive cycles; pos increments with each strobe.
- The cycle after the last strobe: adv_ack=1 for one cycle.
- Then DONE if pos_start+L >= block_len, else READY.
- adv_req is ignored during ADV. The requester holds off until adv_ack.

DONE:
- done=1, in_ready=0, no strobes.
- Only rst leaves DONE, because the buffer pointers rewind only on rst.

Other rules:
- start outside IDLE is ignored.
- buf_load and buf_load_input are never high in the same cycle.
- pos never exceeds block_len-1.
- block_len=1 means any advance goes straight to DONE with zero strobes.

Decomposition:
- Shared package lz77_pkg: DEPTH, CW, DW constants and the state enum (IDLE, FILL, READY, ADV, DONE), reused by the match-engine controller.
- No sub-module. A single FSM with two counters (wr_cnt, load countdown) is the natural size.

Test Plan:
1. Reset, start, stream 5 bytes 0x41..0x45 back-to-back with in_last on 0x45 -> five buf_load_input strobes on consecutive cycles, each 1 cycle after its accept, data matches; block_len=5; state READY; pos=0.
2. Stream 34 bytes with no in_last -> in_ready drops after byte 30; exactly 30 write strobes; block_len=30; bytes 31-34 not accepted.
3. After scenario 1: adv_req with adv_len=3 -> 3 consecutive buf_load strobes, pos=3, adv_ack one cycle after the last strobe, done=0.
4. Then adv_len=4 (overshoot) -> exactly 1 buf_load strobe, pos=4, adv_ack, then done=1 and held.
5. adv_len=0 in READY with pos=1, block_len=5 -> no strobe, adv_ack next cycle, pos stays 1.
6. Assert rst during ADV of adv_len=6 after 2 strobes -> next cycle all outputs at reset values, no further buf_load; a new start then refills from byte 0.
